// File: rtl/br_ctrl.sv
// br_ctrl: branch resolution controller with a 2-bit-counter BHT.
//
// Purpose
//   Drives brcomp's br_unsign from funct3 and decodes br_less/br_equal into a
//   taken/not-taken outcome. Compares that outcome against the IF-stage
//   prediction and, on a mispredict, issues a registered one-cycle flush and a
//   redirect PC. Owns a BHT of 2-bit counters that predicts in IF and trains in EX.
//
// Ports
//   clk_i, rst_i       clock and synchronous active-high reset
//   if_pc_i            fetch PC used for the BHT lookup
//   if_pred_taken_o    prediction for if_pc_i (combinational)
//   ex_valid_i         EX holds a conditional branch
//   ex_funct3_i        branch funct3
//   ex_pc_i            PC of the EX branch
//   ex_target_i        computed branch target
//   ex_pred_taken_i    prediction carried down with the branch
//   br_unsign_o        brcomp unsigned-compare select
//   br_less_i          brcomp less-than result
//   br_equal_i         brcomp equal result
//   flush_o            one-cycle pulse: kill IF/ID, redirect fetch
//   redirect_pc_o      fetch target while flush_o=1, otherwise 0
//   br_illegal_o       one-cycle pulse: reserved funct3 seen
//
// Optional feature: define BR_CTRL_STATS_EN to add stat_br_o (resolved
// branches) and stat_miss_o (mispredicts) counters.

module br_ctrl #(
    parameter int         BHT_ENTRIES = 64,
    parameter logic [1:0] RST_CNT     = 2'b01
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] if_pc_i,
    output logic        if_pred_taken_o,
    input  logic        ex_valid_i,
    input  logic [2:0]  ex_funct3_i,
    input  logic [31:0] ex_pc_i,
    input  logic [31:0] ex_target_i,
    input  logic        ex_pred_taken_i,
    output logic        br_unsign_o,
    input  logic        br_less_i,
    input  logic        br_equal_i,
    output logic        flush_o,
    output logic [31:0] redirect_pc_o,
    output logic        br_illegal_o
`ifdef BR_CTRL_STATS_EN
    ,
    output logic [31:0] stat_br_o,
    output logic [31:0] stat_miss_o
`endif
);

    localparam int IW = $clog2(BHT_ENTRIES);

    logic [1:0]    cnt [BHT_ENTRIES];
    logic [IW-1:0] if_idx;
    logic [IW-1:0] ex_idx;

    logic taken;
    logic is_br;
    logic active;
    logic resolve;
    logic illegal;
    logic miss;

    // Only the index bits of if_pc_i select a counter; the rest alias.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{if_pc_i[31:IW+2], if_pc_i[1:0]};

    assign if_idx          = if_pc_i[IW+1:2];
    assign ex_idx          = ex_pc_i[IW+1:2];
    assign if_pred_taken_o = cnt[if_idx][1];
    assign br_unsign_o     = ex_funct3_i[1];

    always_comb begin
        taken = 1'b0;
        is_br = 1'b1;
        unique case (ex_funct3_i)
            3'b000:         taken = br_equal_i;
            3'b001:         taken = ~br_equal_i;
            3'b100, 3'b110: taken = br_less_i;
            3'b101, 3'b111: taken = ~br_less_i;
            default:        is_br = 1'b0;
        endcase
        // The instruction in EX during a flush cycle is on the wrong path.
        active  = ex_valid_i & ~flush_o;
        resolve = active & is_br;
        illegal = active & ~is_br;
        miss    = resolve & (taken ^ ex_pred_taken_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            flush_o       <= 1'b0;
            redirect_pc_o <= 32'd0;
            br_illegal_o  <= 1'b0;
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                cnt[i] <= RST_CNT;
            end
        end else begin
            flush_o       <= miss;
            br_illegal_o  <= illegal;
            if (miss) begin
                redirect_pc_o <= taken ? ex_target_i : ex_pc_i + 32'd4;
            end else begin
                redirect_pc_o <= 32'd0;
            end
            if (resolve) begin
                if (taken && cnt[ex_idx] != 2'b11) begin
                    cnt[ex_idx] <= cnt[ex_idx] + 2'b01;
                end else if (!taken && cnt[ex_idx] != 2'b00) begin
                    cnt[ex_idx] <= cnt[ex_idx] - 2'b01;
                end
            end
        end
    end

`ifdef BR_CTRL_STATS_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_br_o   <= 32'd0;
            stat_miss_o <= 32'd0;
        end else begin
            if (resolve) begin
                stat_br_o <= stat_br_o + 32'd1;
            end
            if (miss) begin
                stat_miss_o <= stat_miss_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_br_ctrl.sv
// tb_br_ctrl: self-checking bench for br_ctrl.
// Table-driven branch vectors plus hand-written multi-cycle sequences.

module tb_br_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] if_pc_i;
    logic        if_pred_taken_o;
    logic        ex_valid_i;
    logic [2:0]  ex_funct3_i;
    logic [31:0] ex_pc_i;
    logic [31:0] ex_target_i;
    logic        ex_pred_taken_i;
    logic        br_unsign_o;
    logic        br_less_i;
    logic        br_equal_i;
    logic        flush_o;
    logic [31:0] redirect_pc_o;
    logic        br_illegal_o;
`ifdef BR_CTRL_STATS_EN
    logic [31:0] stat_br_o;
    logic [31:0] stat_miss_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    br_ctrl #(.BHT_ENTRIES(64), .RST_CNT(2'b01)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .if_pc_i         (if_pc_i),
        .if_pred_taken_o (if_pred_taken_o),
        .ex_valid_i      (ex_valid_i),
        .ex_funct3_i     (ex_funct3_i),
        .ex_pc_i         (ex_pc_i),
        .ex_target_i     (ex_target_i),
        .ex_pred_taken_i (ex_pred_taken_i),
        .br_unsign_o     (br_unsign_o),
        .br_less_i       (br_less_i),
        .br_equal_i      (br_equal_i),
        .flush_o         (flush_o),
        .redirect_pc_o   (redirect_pc_o),
        .br_illegal_o    (br_illegal_o)
`ifdef BR_CTRL_STATS_EN
        ,
        .stat_br_o       (stat_br_o),
        .stat_miss_o     (stat_miss_o)
`endif
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        pred;
        logic        less;
        logic        eq;
        logic        x_uns;
        logic        x_flush;
        logic [31:0] x_redir;
        logic        x_ill;
        logic        x_pred;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        ex_funct3_i     = v.f3;
        ex_pc_i         = v.pc;
        ex_target_i     = v.tgt;
        ex_pred_taken_i = v.pred;
        br_less_i       = v.less;
        br_equal_i      = v.eq;
    endtask

    // One branch in EX for one cycle, then an idle cycle.
    task automatic run_vec(input vec_t v, input string nm);
        @(negedge clk_i);
        drive(v);
        ex_valid_i = 1'b1;
        #1;
        chk({nm, " unsign"}, 32'(br_unsign_o), 32'(v.x_uns));
        @(posedge clk_i);
        #1;
        ex_valid_i = 1'b0;
        chk({nm, " flush"}, 32'(flush_o), 32'(v.x_flush));
        chk({nm, " redirect"}, redirect_pc_o, v.x_redir);
        chk({nm, " illegal"}, 32'(br_illegal_o), 32'(v.x_ill));
        if_pc_i = v.pc;
        #1;
        chk({nm, " pred"}, 32'(if_pred_taken_o), 32'(v.x_pred));
        @(posedge clk_i);
        #1;
        chk({nm, " flush drop"}, 32'(flush_o), 32'd0);
        chk({nm, " illegal drop"}, 32'(br_illegal_o), 32'd0);
    endtask

    task automatic chk_all_pred(input string nm);
        for (int i = 0; i < 64; i++) begin
            if_pc_i = 32'(i) << 2;
            #1;
            chk($sformatf("%s idx%0d", nm, i), 32'(if_pred_taken_o), 32'd0);
        end
    endtask

    initial begin
        vec_t s;

        //          f3      pc            tgt           pr less eq  uns fl redir         il pr
        vecs[0]  = '{3'b000, 32'h100,      32'h140,      0, 0, 1,  0, 1, 32'h140,      0, 1};
        vecs[1]  = '{3'b111, 32'h200,      32'h280,      1, 1, 0,  1, 1, 32'h204,      0, 0};
        vecs[2]  = '{3'b001, 32'hFFFFFFFC, 32'h10,       1, 0, 1,  0, 1, 32'h0,        0, 0};
        vecs[3]  = '{3'b100, 32'h300,      32'h380,      0, 1, 0,  0, 1, 32'h380,      0, 1};
        vecs[4]  = '{3'b100, 32'h300,      32'h380,      1, 1, 0,  0, 0, 32'h0,        0, 1};
        vecs[5]  = '{3'b100, 32'h300,      32'h380,      1, 1, 0,  0, 0, 32'h0,        0, 1};
        vecs[6]  = '{3'b100, 32'h300,      32'h380,      1, 1, 0,  0, 0, 32'h0,        0, 1};
        vecs[7]  = '{3'b110, 32'h300,      32'h380,      1, 0, 0,  1, 1, 32'h304,      0, 1};
        vecs[8]  = '{3'b101, 32'h300,      32'h380,      1, 1, 0,  0, 1, 32'h304,      0, 0};
        vecs[9]  = '{3'b010, 32'h300,      32'h380,      0, 0, 0,  1, 0, 32'h0,        1, 0};
        vecs[10] = '{3'b001, 32'h104,      32'h50,       0, 0, 0,  0, 1, 32'h50,       0, 1};
        vecs[11] = '{3'b000, 32'h108,      32'h200,      0, 0, 0,  0, 0, 32'h0,        0, 0};
        vecs[12] = '{3'b011, 32'h108,      32'h200,      0, 0, 0,  1, 0, 32'h0,        1, 0};

        rst_i           = 1'b1;
        ex_valid_i      = 1'b0;
        if_pc_i         = 32'd0;
        ex_funct3_i     = 3'd0;
        ex_pc_i         = 32'd0;
        ex_target_i     = 32'd0;
        ex_pred_taken_i = 1'b0;
        br_less_i       = 1'b0;
        br_equal_i      = 1'b0;
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        chk("reset flush", 32'(flush_o), 32'd0);
        chk("reset redirect", redirect_pc_o, 32'd0);
        chk("reset illegal", 32'(br_illegal_o), 32'd0);
        chk_all_pred("reset pred");
`ifdef BR_CTRL_STATS_EN
        chk("reset stat_br", stat_br_o, 32'd0);
        chk("reset stat_miss", stat_miss_o, 32'd0);
`endif

        for (int i = 0; i < 13; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Mispredict followed by a mispredicting branch in the flush cycle:
        // the second one must be dropped and train nothing.
        s = '{3'b000, 32'h400, 32'h440, 0, 0, 1, 0, 0, 0, 0, 0};
        @(negedge clk_i);
        drive(s);
        ex_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("supp flush", 32'(flush_o), 32'd1);
        chk("supp redirect", redirect_pc_o, 32'h440);
        ex_target_i = 32'h999;
        @(posedge clk_i);
        #1;
        ex_valid_i = 1'b0;
        chk("supp second flush", 32'(flush_o), 32'd0);
        chk("supp second redirect", redirect_pc_o, 32'd0);
        chk("supp second illegal", 32'(br_illegal_o), 32'd0);
        // Counter is 10 if trained once; one not-taken brings prediction to 0.
        s = '{3'b000, 32'h400, 32'h440, 1, 0, 0, 0, 1, 32'h404, 0, 0};
        run_vec(s, "supp once");

        // Reserved funct3 in a flush cycle must not pulse br_illegal_o.
        s = '{3'b001, 32'h400, 32'h480, 0, 0, 0, 0, 0, 0, 0, 0};
        @(negedge clk_i);
        drive(s);
        ex_valid_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("supp ill flush", 32'(flush_o), 32'd1);
        chk("supp ill redirect", redirect_pc_o, 32'h480);
        ex_funct3_i = 3'b010;
        @(posedge clk_i);
        #1;
        ex_valid_i = 1'b0;
        chk("supp ill pulse", 32'(br_illegal_o), 32'd0);
        chk("supp ill flush2", 32'(flush_o), 32'd0);

        // Reset during the resolve cycle of a mispredict.
        s = '{3'b001, 32'h104, 32'h50, 0, 0, 0, 0, 0, 0, 0, 0};
        @(negedge clk_i);
        drive(s);
        ex_valid_i = 1'b1;
        rst_i      = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i      = 1'b0;
        ex_valid_i = 1'b0;
        chk("rst flush", 32'(flush_o), 32'd0);
        chk("rst redirect", redirect_pc_o, 32'd0);
        @(posedge clk_i);
        #1;
        chk("rst flush late", 32'(flush_o), 32'd0);
        chk_all_pred("rst pred");

`ifdef BR_CTRL_STATS_EN
        chk("rst stat_br", stat_br_o, 32'd0);
        chk("rst stat_miss", stat_miss_o, 32'd0);
        s = '{3'b000, 32'h600, 32'h640, 0, 0, 0, 0, 0, 32'h0,   0, 0};
        run_vec(s, "stat0");
        s = '{3'b001, 32'h600, 32'h640, 0, 0, 0, 0, 1, 32'h640, 0, 0};
        run_vec(s, "stat1");
        s = '{3'b110, 32'h600, 32'h640, 0, 0, 0, 1, 0, 32'h0,   0, 0};
        run_vec(s, "stat2");
        s = '{3'b010, 32'h600, 32'h640, 0, 0, 0, 1, 0, 32'h0,   1, 0};
        run_vec(s, "stat3");
        chk("stat_br", stat_br_o, 32'd3);
        chk("stat_miss", stat_miss_o, 32'd1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
